// File: rtl/cmd_dispatch_arbiter_pkg.sv
// Shared definitions for the command dispatch arbiter: target decode fields,
// the local status address and the read-tracking FSM encoding.
package cmd_dispatch_arbiter_pkg;

  localparam int NUM_TGT     = 4;
  localparam int ADDR_W      = 19;
  localparam int DATA_W      = 32;
  localparam int TGT_SEL_MSB = 18;
  localparam int TGT_SEL_LSB = 17;

  localparam logic [ADDR_W-1:0] STATUS_ADDR = 19'h7FFFF;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } arb_state_t;

  function automatic logic [NUM_TGT-1:0] tgt_onehot(input logic [1:0] sel);
    return 4'b0001 << sel;
  endfunction

endpackage

// File: rtl/cmd_resp_timer.sv
// Read-response watchdog: counts WAIT cycles, flags expiry, and keeps the
// saturating timeout and dropped-read counters reported as {drop, timeout}.
module cmd_resp_timer #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_waiting,
  input  logic        i_resp_hit,
  input  logic        i_drop,
  output logic        o_expire,
  output logic [31:0] ov_status
);

  logic [7:0]  timer_reg;
  logic [15:0] timeout_cnt_reg;
  logic [15:0] drop_cnt_reg;

  // A response landing in the expiry cycle suppresses the timeout.
  assign o_expire  = i_waiting && !i_resp_hit && (timer_reg == 8'(TIMEOUT_CYC - 1));
  assign ov_status = {drop_cnt_reg, timeout_cnt_reg};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      timer_reg       <= '0;
      timeout_cnt_reg <= '0;
      drop_cnt_reg    <= '0;
    end else begin
      timer_reg <= i_waiting ? timer_reg + 8'd1 : 8'd0;
      if (o_expire && timeout_cnt_reg != 16'hFFFF) begin
        timeout_cnt_reg <= timeout_cnt_reg + 16'd1;
      end
      if (i_drop && drop_cnt_reg != 16'hFFFF) begin
        drop_cnt_reg <= drop_cnt_reg + 16'd1;
      end
    end
  end

endmodule

// File: rtl/cmd_dispatch_arbiter.sv
// Command dispatch to four targets with a single outstanding read and timeout.
// Optional DISPATCH_STATUS_EN serves {drop_cnt,timeout_cnt} at fixed addr 19'h7FFFF.
module cmd_dispatch_arbiter
  import cmd_dispatch_arbiter_pkg::*;
#(
  parameter int          TIMEOUT_CYC = 16,
  parameter logic [31:0] ERR_RDATA   = 32'hDEAD_BEEF
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [18:0]  iv_addr,
  input  logic         i_addr_fixed,
  input  logic [31:0]  iv_wdata,
  input  logic         i_wr,
  input  logic         i_rd,
  output logic         o_busy,
  output logic [18:0]  ov_addr_tgt,
  output logic         o_addr_fixed_tgt,
  output logic [31:0]  ov_wdata_tgt,
  output logic [3:0]   ov_wr_tgt,
  output logic [3:0]   ov_rd_tgt,
  input  logic [3:0]   iv_resp_wr,
  input  logic [75:0]  iv_resp_addr,
  input  logic [3:0]   iv_resp_addr_fixed,
  input  logic [127:0] iv_resp_rdata,
  output logic         o_wr,
  output logic [18:0]  ov_addr,
  output logic         o_addr_fixed,
  output logic [31:0]  ov_rdata
);

  arb_state_t         state_reg;
  logic [1:0]         tgt_reg;
  logic [ADDR_W-1:0]  addr_reg;
  logic               fixed_reg;

  logic [ADDR_W-1:0]  resp_addr_arr  [NUM_TGT];
  logic [DATA_W-1:0]  resp_rdata_arr [NUM_TGT];

  logic [1:0]         tgt_sel;
  logic [NUM_TGT-1:0] sel_onehot;
  logic               rd_eff;
  logic               idle;
  logic               status_hit;
  logic               rd_dispatch;
  logic               rd_drop;
  logic               resp_hit;
  logic               expire;
  logic [31:0]        status_word;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_TGT; gi++) begin : g_resp_unpack
      assign resp_addr_arr[gi]  = iv_resp_addr[ADDR_W*gi +: ADDR_W];
      assign resp_rdata_arr[gi] = iv_resp_rdata[DATA_W*gi +: DATA_W];
    end
  endgenerate

  assign tgt_sel    = iv_addr[TGT_SEL_MSB:TGT_SEL_LSB];
  assign sel_onehot = tgt_onehot(tgt_sel);
  assign rd_eff     = i_rd && !i_wr;
  assign idle       = (state_reg == ST_IDLE);

`ifdef DISPATCH_STATUS_EN
  assign status_hit = i_addr_fixed && (iv_addr == STATUS_ADDR);
`else
  assign status_hit = 1'b0;
`endif

  assign rd_dispatch = rd_eff && idle && !status_hit;
  assign rd_drop     = rd_eff && !idle;
  assign resp_hit    = !idle && iv_resp_wr[tgt_reg];

  cmd_resp_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timer (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_waiting  (!idle),
    .i_resp_hit (resp_hit),
    .i_drop     (rd_drop),
    .o_expire   (expire),
    .ov_status  (status_word)
  );

  // Target side: strobes and their payload are zero outside a forwarded strobe.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ov_wr_tgt        <= '0;
      ov_rd_tgt        <= '0;
      ov_addr_tgt      <= '0;
      o_addr_fixed_tgt <= 1'b0;
      ov_wdata_tgt     <= '0;
    end else begin
      ov_wr_tgt <= i_wr ? sel_onehot : '0;
      ov_rd_tgt <= rd_dispatch ? sel_onehot : '0;
      if (i_wr || rd_dispatch) begin
        ov_addr_tgt      <= iv_addr;
        o_addr_fixed_tgt <= i_addr_fixed;
        ov_wdata_tgt     <= iv_wdata;
      end else begin
        ov_addr_tgt      <= '0;
        o_addr_fixed_tgt <= 1'b0;
        ov_wdata_tgt     <= '0;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg    <= ST_IDLE;
      tgt_reg      <= '0;
      addr_reg     <= '0;
      fixed_reg    <= 1'b0;
      o_busy       <= 1'b0;
      o_wr         <= 1'b0;
      ov_addr      <= '0;
      o_addr_fixed <= 1'b0;
      ov_rdata     <= '0;
    end else begin
      o_wr         <= 1'b0;
      ov_addr      <= '0;
      o_addr_fixed <= 1'b0;
      ov_rdata     <= '0;
      case (state_reg)
        ST_IDLE: begin
          if (rd_eff && status_hit) begin
            o_wr         <= 1'b1;
            ov_addr      <= iv_addr;
            o_addr_fixed <= i_addr_fixed;
            ov_rdata     <= status_word;
          end else if (rd_dispatch) begin
            state_reg <= ST_WAIT;
            o_busy    <= 1'b1;
            tgt_reg   <= tgt_sel;
            addr_reg  <= iv_addr;
            fixed_reg <= i_addr_fixed;
          end
        end
        ST_WAIT: begin
          if (resp_hit) begin
            state_reg    <= ST_IDLE;
            o_busy       <= 1'b0;
            o_wr         <= 1'b1;
            ov_addr      <= resp_addr_arr[tgt_reg];
            o_addr_fixed <= iv_resp_addr_fixed[tgt_reg];
            ov_rdata     <= resp_rdata_arr[tgt_reg];
          end else if (expire) begin
            state_reg    <= ST_IDLE;
            o_busy       <= 1'b0;
            o_wr         <= 1'b1;
            ov_addr      <= addr_reg;
            o_addr_fixed <= fixed_reg;
            ov_rdata     <= ERR_RDATA;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_dispatch_arbiter.sv
// Directed vector bench for cmd_dispatch_arbiter (default TIMEOUT_CYC=16).
module tb_cmd_dispatch_arbiter;

  typedef struct {
    logic        wr;
    logic        rd;
    logic [18:0] addr;
    logic        fixed;
    logic [31:0] wdata;
    logic [3:0]  resp_wr;
    logic [18:0] resp_addr;
    logic        resp_fixed;
    logic [31:0] resp_rdata;
    logic [3:0]  e_wr_tgt;
    logic [3:0]  e_rd_tgt;
    logic [18:0] e_addr_tgt;
    logic        e_fixed_tgt;
    logic [31:0] e_wdata_tgt;
    logic        e_wr;
    logic [18:0] e_addr;
    logic        e_fixed;
    logic [31:0] e_rdata;
    logic        e_busy;
  } vec_t;

  logic         clk;
  logic         rst_n;
  logic [18:0]  addr;
  logic         fixed;
  logic [31:0]  wdata;
  logic         wr;
  logic         rd;
  logic         busy;
  logic [18:0]  addr_tgt;
  logic         fixed_tgt;
  logic [31:0]  wdata_tgt;
  logic [3:0]   wr_tgt;
  logic [3:0]   rd_tgt;
  logic [3:0]   resp_wr;
  logic [75:0]  resp_addr;
  logic [3:0]   resp_fixed;
  logic [127:0] resp_rdata;
  logic         up_wr;
  logic [18:0]  up_addr;
  logic         up_fixed;
  logic [31:0]  up_rdata;

  int total;
  int bad;

  cmd_dispatch_arbiter dut (
    .i_clk              (clk),
    .i_rst_n            (rst_n),
    .iv_addr            (addr),
    .i_addr_fixed       (fixed),
    .iv_wdata           (wdata),
    .i_wr               (wr),
    .i_rd               (rd),
    .o_busy             (busy),
    .ov_addr_tgt        (addr_tgt),
    .o_addr_fixed_tgt   (fixed_tgt),
    .ov_wdata_tgt       (wdata_tgt),
    .ov_wr_tgt          (wr_tgt),
    .ov_rd_tgt          (rd_tgt),
    .iv_resp_wr         (resp_wr),
    .iv_resp_addr       (resp_addr),
    .iv_resp_addr_fixed (resp_fixed),
    .iv_resp_rdata      (resp_rdata),
    .o_wr               (up_wr),
    .ov_addr            (up_addr),
    .o_addr_fixed       (up_fixed),
    .ov_rdata           (up_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t idle_vec(input logic exp_busy);
    vec_t v;
    v = '{1'b0, 1'b0, 19'h0, 1'b0, 32'h0, 4'b0, 19'h0, 1'b0, 32'h0,
          4'b0, 4'b0, 19'h0, 1'b0, 32'h0, 1'b0, 19'h0, 1'b0, 32'h0, exp_busy};
    return v;
  endfunction

  // Target k responds with addr base|{k,17'h0} and rdata base+k.
  task automatic apply(input vec_t v);
    wr      = v.wr;
    rd      = v.rd;
    addr    = v.addr;
    fixed   = v.fixed;
    wdata   = v.wdata;
    resp_wr = v.resp_wr;
    for (int k = 0; k < 4; k++) begin
      resp_addr[19*k +: 19]  = v.resp_addr | {2'(k), 17'h0};
      resp_rdata[32*k +: 32] = v.resp_rdata + 32'(k);
      resp_fixed[k]          = v.resp_fixed;
    end
  endtask

  task automatic check_outputs(input string tag, input vec_t v);
    chk({tag, ".wr_tgt"},    32'(wr_tgt),    32'(v.e_wr_tgt));
    chk({tag, ".rd_tgt"},    32'(rd_tgt),    32'(v.e_rd_tgt));
    chk({tag, ".addr_tgt"},  32'(addr_tgt),  32'(v.e_addr_tgt));
    chk({tag, ".fixed_tgt"}, 32'(fixed_tgt), 32'(v.e_fixed_tgt));
    chk({tag, ".wdata_tgt"}, wdata_tgt,      v.e_wdata_tgt);
    chk({tag, ".o_wr"},      32'(up_wr),     32'(v.e_wr));
    chk({tag, ".ov_addr"},   32'(up_addr),   32'(v.e_addr));
    chk({tag, ".o_fixed"},   32'(up_fixed),  32'(v.e_fixed));
    chk({tag, ".ov_rdata"},  up_rdata,       v.e_rdata);
    chk({tag, ".o_busy"},    32'(busy),      32'(v.e_busy));
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    apply(v);
    @(posedge clk);
    #1;
    check_outputs(tag, v);
    $display("%s: wr_tgt=%b rd_tgt=%b o_wr=%b addr=%h rdata=%h busy=%b",
             tag, wr_tgt, rd_tgt, up_wr, up_addr, up_rdata, busy);
  endtask

  vec_t tbl [9];
  vec_t v;

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    apply(idle_vec(1'b0));

    //       wr    rd    addr        fx    wdata          rsp_wr   rsp_addr    rfx   rsp_rdata
    //       e_wr_tgt e_rd_tgt e_addr_tgt e_fx e_wdata      e_owr e_addr     e_fx  e_rdata      busy
    tbl[0] = '{1'b1, 1'b0, 19'h20004, 1'b0, 32'h12345678, 4'b0000, 19'h00000, 1'b0, 32'h0,
               4'b0010, 4'b0000, 19'h20004, 1'b0, 32'h12345678, 1'b0, 19'h0, 1'b0, 32'h0, 1'b0};
    tbl[1] = '{1'b0, 1'b0, 19'h00000, 1'b0, 32'h0, 4'b1111, 19'h00100, 1'b1, 32'h1,
               4'b0000, 4'b0000, 19'h0, 1'b0, 32'h0, 1'b0, 19'h0, 1'b0, 32'h0, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 19'h00000, 1'b1, 32'h0, 4'b0000, 19'h00000, 1'b0, 32'h0,
               4'b0000, 4'b0001, 19'h0, 1'b1, 32'h0, 1'b0, 19'h0, 1'b0, 32'h0, 1'b1};
    tbl[3] = idle_vec(1'b1);
    tbl[4] = '{1'b0, 1'b0, 19'h00000, 1'b0, 32'h0, 4'b0010, 19'h00ABC, 1'b0, 32'h99,
               4'b0000, 4'b0000, 19'h0, 1'b0, 32'h0, 1'b0, 19'h0, 1'b0, 32'h0, 1'b1};
    tbl[5] = '{1'b0, 1'b1, 19'h40008, 1'b0, 32'h0, 4'b0000, 19'h00000, 1'b0, 32'h0,
               4'b0000, 4'b0000, 19'h0, 1'b0, 32'h0, 1'b0, 19'h0, 1'b0, 32'h0, 1'b1};
    tbl[6] = '{1'b0, 1'b0, 19'h00000, 1'b0, 32'h0, 4'b0001, 19'h00010, 1'b1, 32'h55,
               4'b0000, 4'b0000, 19'h0, 1'b0, 32'h0, 1'b1, 19'h00010, 1'b1, 32'h55, 1'b0};
    tbl[7] = '{1'b0, 1'b1, 19'h40008, 1'b0, 32'h0, 4'b0000, 19'h00000, 1'b0, 32'h0,
               4'b0000, 4'b0100, 19'h40008, 1'b0, 32'h0, 1'b0, 19'h0, 1'b0, 32'h0, 1'b1};
    tbl[8] = '{1'b1, 1'b1, 19'h20040, 1'b0, 32'hAA, 4'b0000, 19'h00000, 1'b0, 32'h0,
               4'b0010, 4'b0000, 19'h20040, 1'b0, 32'hAA, 1'b0, 19'h0, 1'b0, 32'h0, 1'b1};

    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset", idle_vec(1'b0));
    rst_n = 1'b1;

    // Table: write, idle response, read/foreign/drop/response, back-to-back read, wr+rd.
    for (int i = 0; i < 9; i++) begin
      run_vec($sformatf("vec%0d", i), tbl[i]);
    end

    // Timeout: edges 2..15 of WAIT are quiet, edge 16 expires.
    for (int i = 0; i < 14; i++) begin
      run_vec($sformatf("tmo_wait%0d", i), idle_vec(1'b1));
    end
    v = idle_vec(1'b0);
    v.e_wr    = 1'b1;
    v.e_addr  = 19'h40008;
    v.e_rdata = 32'hDEADBEEF;
    run_vec("tmo_expire", v);
    chk("timeout_cnt_after_tmo", 32'(dut.u_timer.timeout_cnt_reg), 32'd1);
    chk("drop_cnt_after_tmo",    32'(dut.u_timer.drop_cnt_reg),    32'd1);

    // Race: response from target 3 lands on the expiry edge.
    v = idle_vec(1'b1);
    v.rd         = 1'b1;
    v.addr       = 19'h60020;
    v.e_rd_tgt   = 4'b1000;
    v.e_addr_tgt = 19'h60020;
    run_vec("race_rd", v);
    for (int i = 0; i < 15; i++) begin
      run_vec($sformatf("race_wait%0d", i), idle_vec(1'b1));
    end
    v = idle_vec(1'b0);
    v.resp_wr    = 4'b1000;
    v.resp_addr  = 19'h00030;
    v.resp_fixed = 1'b1;
    v.resp_rdata = 32'h77;
    v.e_wr       = 1'b1;
    v.e_addr     = 19'h60030;
    v.e_fixed    = 1'b1;
    v.e_rdata    = 32'h7A;
    run_vec("race_resp", v);
    chk("timeout_cnt_after_race", 32'(dut.u_timer.timeout_cnt_reg), 32'd1);

    // Fixed read of the status address.
    v = idle_vec(1'b0);
    v.rd    = 1'b1;
    v.addr  = 19'h7FFFF;
    v.fixed = 1'b1;
`ifdef DISPATCH_STATUS_EN
    v.e_wr    = 1'b1;
    v.e_addr  = 19'h7FFFF;
    v.e_fixed = 1'b1;
    v.e_rdata = 32'h00010001;
    run_vec("status_rd", v);
    v = idle_vec(1'b1);
    v.rd         = 1'b1;
    v.addr       = 19'h20000;
    v.e_rd_tgt   = 4'b0010;
    v.e_addr_tgt = 19'h20000;
    run_vec("pre_reset_rd", v);
`else
    v.e_rd_tgt    = 4'b1000;
    v.e_addr_tgt  = 19'h7FFFF;
    v.e_fixed_tgt = 1'b1;
    v.e_busy      = 1'b1;
    run_vec("status_addr_rd_t3", v);
`endif
    run_vec("pre_reset_wait0", idle_vec(1'b1));
    run_vec("pre_reset_wait1", idle_vec(1'b1));

    // Asynchronous reset mid-read: outputs clear at once, no response follows.
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs("async_reset", idle_vec(1'b0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      run_vec($sformatf("post_reset%0d", i), idle_vec(1'b0));
    end
    chk("timeout_cnt_after_reset", 32'(dut.u_timer.timeout_cnt_reg), 32'd0);
    chk("drop_cnt_after_reset",    32'(dut.u_timer.drop_cnt_reg),    32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
